// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
//   Shared definitions for the instruction-fetch slice: default address and
//   instruction widths, the sequential PC step, the reset PC and the fetch
//   state encoding used by fetch_unit.
//   No ports (package only).

package fetch_unit_pkg;

    localparam int          FU_ADDR     = 32;
    localparam int          FU_W_INST   = 32;
    localparam int          FU_PC_STEP  = 4;
    localparam logic [63:0] FU_RESET_PC = 64'h0;

    // REQ issues one request, WAIT waits for the response, HOLD presents
    // the fetched instruction to decode until it is taken.
    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_buffer.sv
// fetch_buffer
//   Single-entry holding register between the fetch FSM and decode.
//   Ports:
//     clk_i, rst_i   clock and synchronous active-high reset
//     load_i         capture inst_i/pc_i and mark the entry valid
//     consume_i      decode took the entry; mark it empty
//     clear_i        redirect; discard the entry
//     inst_i, pc_i   instruction and its address to capture
//     valid_o        entry holds an instruction
//     inst_o, pc_o   held instruction and its address
//   Priority is clear > load > consume. Data is kept when the entry is
//   emptied so the outputs do not toggle needlessly.

module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int ADDR   = FU_ADDR,
    parameter int W_INST = FU_W_INST
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              consume_i,
    input  logic              clear_i,
    input  logic [W_INST-1:0] inst_i,
    input  logic [ADDR-1:0]   pc_i,
    output logic              valid_o,
    output logic [W_INST-1:0] inst_o,
    output logic [ADDR-1:0]   pc_o
);

    logic              valid_q, valid_d;
    logic [W_INST-1:0] inst_q, inst_d;
    logic [ADDR-1:0]   pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            inst_d  = inst_i;
            pc_d    = pc_i;
        end else if (consume_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage. Owns the PC, issues one request at a time to
//   instruction memory and offers each fetched instruction to decode with a
//   valid/stall handshake. A redirect from execute reloads the PC, discards
//   anything in flight or buffered and pulses flush_o for one cycle.
//   Ports:
//     clk_i, rst_i                 clock, synchronous active-high reset
//     branch_i, branch_addr_i      redirect request and target
//     stall_i                      decode cannot accept this cycle
//     imem_req_o, imem_addr_o      memory request strobe and address
//     imem_ack_i, imem_data_i      memory response strobe and data
//     v_o, inst_o, pc_o            instruction offered to decode
//     flush_o                      one-cycle pipeline flush pulse
//   Optional: define FETCH_STATS_EN to add stat_fetch_o (instructions taken
//   by decode) and stat_drop_o (responses/instructions lost to redirects).

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              ADDR     = FU_ADDR,
    parameter int              W_INST   = FU_W_INST,
    parameter int              PC_STEP  = FU_PC_STEP,
    parameter logic [ADDR-1:0] RESET_PC = ADDR'(FU_RESET_PC)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              branch_i,
    input  logic [ADDR-1:0]   branch_addr_i,
    input  logic              stall_i,
    output logic              imem_req_o,
    output logic [ADDR-1:0]   imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [W_INST-1:0] imem_data_i,
    output logic              v_o,
    output logic [W_INST-1:0] inst_o,
    output logic [ADDR-1:0]   pc_o,
    output logic              flush_o
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       stat_fetch_o,
    output logic [31:0]       stat_drop_o
`endif
);

    fetch_state_t    state_q, state_d;
    logic [ADDR-1:0] pc_q, pc_d;
    logic [ADDR-1:0] req_pc_q, req_pc_d;
    logic            drop_q, drop_d;
    logic            flush_q, flush_d;
    logic            buf_load, buf_consume;

    // The drop flag marks that the response we are waiting for belongs to a
    // request issued before a redirect and must be thrown away.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        drop_d      = drop_q;
        flush_d     = 1'b0;
        buf_load    = 1'b0;
        buf_consume = 1'b0;

        unique case (state_q)
            FS_REQ: begin
                req_pc_d = pc_q;
                state_d  = FS_WAIT;
            end
            FS_WAIT: begin
                if (imem_ack_i) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = FS_REQ;
                    end else begin
                        buf_load = 1'b1;
                        pc_d     = req_pc_q + ADDR'(PC_STEP);
                        state_d  = FS_HOLD;
                    end
                end
            end
            FS_HOLD: begin
                if (!stall_i) begin
                    buf_consume = 1'b1;
                    state_d     = FS_REQ;
                end
            end
            default: state_d = FS_REQ;
        endcase

        // A redirect overrides everything above. A request still in flight
        // (issued in REQ, or waited on in WAIT with no response yet) must
        // have its response dropped later; a response arriving right now is
        // simply not loaded.
        if (branch_i) begin
            pc_d        = branch_addr_i;
            state_d     = FS_REQ;
            flush_d     = 1'b1;
            buf_load    = 1'b0;
            buf_consume = 1'b0;
            if (state_q == FS_REQ) begin
                drop_d = 1'b1;
            end else if (state_q == FS_WAIT) begin
                drop_d = !imem_ack_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= FS_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            drop_q   <= 1'b0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
            flush_q  <= flush_d;
        end
    end

    fetch_buffer #(
        .ADDR   (ADDR),
        .W_INST (W_INST)
    ) u_buffer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (buf_load),
        .consume_i (buf_consume),
        .clear_i   (branch_i),
        .inst_i    (imem_data_i),
        .pc_i      (req_pc_q),
        .valid_o   (v_o),
        .inst_o    (inst_o),
        .pc_o      (pc_o)
    );

    // The request strobe decodes the state register only; it is held low
    // while reset is asserted so nothing is issued during reset.
    assign imem_req_o  = (state_q == FS_REQ) && !rst_i;
    assign imem_addr_o = pc_q;
    assign flush_o     = flush_q;

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetch_q, stat_fetch_d;
    logic [31:0] stat_drop_q, stat_drop_d;

    // Drops cover a response lost to a redirect (now or via the drop flag)
    // and a buffered instruction discarded by a redirect in HOLD.
    always_comb begin
        stat_fetch_d = stat_fetch_q;
        stat_drop_d  = stat_drop_q;
        if (state_q == FS_HOLD && !stall_i && !branch_i) begin
            stat_fetch_d = stat_fetch_q + 32'd1;
        end
        if ((state_q == FS_WAIT && imem_ack_i && (drop_q || branch_i)) ||
            (state_q == FS_HOLD && branch_i)) begin
            stat_drop_d = stat_drop_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_fetch_q <= '0;
            stat_drop_q  <= '0;
        end else begin
            stat_fetch_q <= stat_fetch_d;
            stat_drop_q  <= stat_drop_d;
        end
    end

    assign stat_fetch_o = stat_fetch_q;
    assign stat_drop_o  = stat_drop_q;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage: owns the architectural PC, issues single-outstanding requests to instruction memory and presents fetched instructions to decode with a valid/stall handshake.
- Consumes the redirect pair (branch_i, branch_addr_i) produced by the execute-stage branch unit.
- On a redirect it reloads PC, discards in-flight and buffered instructions, and pulses flush_o to the decode/execute pipeline registers.

Parameters:
- ADDR, 32, PC / instruction-address width.
- W_INST, 32, instruction word width.
- PC_STEP, 4, PC increment per sequential fetch.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- branch_i  in  1  redirect request from execute, valid-qualified upstream.
- branch_addr_i  in  ADDR  redirect target.
- stall_i  in  1  decode cannot accept this cycle.
- imem_req_o  out  1  memory request strobe.
- imem_addr_o  out  ADDR  request address.
- imem_ack_i  in  1  response valid; 1+ cycles after request.
- imem_data_i  in  W_INST  response data, valid with imem_ack_i.
- v_o  out  1  inst_o/pc_o valid to decode.
- inst_o  out  W_INST  fetched instruction.
- pc_o  out  ADDR  address of inst_o.
- flush_o  out  1  one-cycle pipeline flush pulse.

Behaviour:
- Reset (rst_i high at an edge):
  - pc = RESET_PC; state = REQ.
  - imem_req_o = 0, v_o = 0, flush_o = 0, inst_o = 0, pc_o = 0.
  - Drop flag cleared.
  - Reset mid-request abandons it; a later ack without an outstanding request is ignored.
- States:
  - REQ: imem_req_o = 1, imem_addr_o = pc for exactly one cycle. Next state is WAIT; req_pc records pc.
  - WAIT: imem_req_o = 0; waiting for imem_ack_i. On ack:
    - If the drop flag is set: discard the data, clear drop, go to REQ.
    - Otherwise: capture the instruction into the output buffer with pc_o = req_pc, set pc = req_pc + PC_STEP (modulo 2^ADDR, wraps silently), go to HOLD.
  - HOLD: v_o = 1.
    - If stall_i = 0 this cycle, the instruction is consumed; next state is REQ, and v_o drops the following cycle.
    - If stall_i = 1, inst_o, pc_o and v_o hold unchanged.
- Throughput and latency:
  - Maximum one instruction per 3 cycles (REQ, WAIT, HOLD) with 1-cycle memory.
  - Latency from REQ to v_o = memory latency + 1.
- Redirect (branch_i = 1 at an edge), highest priority after reset:
  - pc = branch_addr_i; v_o = 0 next cycle; flush_o = 1 for exactly the next cycle; state = REQ.
  - In WAIT without a same-cycle ack: drop flag set; the stale ack is discarded later and the state returns to REQ via the WAIT/drop path.
  - Ack in the same cycle as branch_i: the data is dropped, no drop flag is needed, state = REQ.
  - In HOLD: the buffered instruction is discarded even if stall_i = 0 (redirect wins over consume).
  - Back-to-back redirects: the last target wins; flush_o stays high on each following cycle.
  - A redirect while in REQ cancels nothing already issued to memory; the drop flag is set because the request went out.
- v_o never asserts with flush_o in the same cycle.
- Outputs are registered; there are no combinational paths from stall_i or branch_i to imem_*.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined:
  - Adds output ports stat_fetch_o (32 bits) and stat_drop_o (32 bits).
  - stat_fetch_o counts instructions consumed by decode (HOLD with stall_i = 0 and no redirect).
  - stat_drop_o counts responses or buffered instructions discarded by redirect.
  - Both counters wrap at 2^32 and are reset to 0 by rst_i.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package (include/params.v): ADDR, W_INST, RESET_PC.
- Fetch-state encoding constants go in include/fetch_states.v: FS_REQ = 2'd0, FS_WAIT = 2'd1, FS_HOLD = 2'd2.
- One sub-module: fetch_buffer, a single-entry holding register.
  - Inputs: load, consume, clear.
  - Outputs: valid, inst, pc.
  - Priority: clear > load > consume.

Test Plan:
- Reset, 1-cycle memory, stall_i = 0:
  - Requests go to addresses 0x0, 0x4, 0x8.
  - v_o pulses every 3rd cycle with pc_o = 0x0, 0x4, 0x8 and inst_o equal to the memory contents.
- stall_i held for 5 cycles during HOLD at pc 0x4:
  - inst_o and pc_o stay stable and v_o stays 1.
  - No imem_req_o occurs until the cycle after stall_i falls.
- 3-cycle memory, branch_i = 1 with target 0x100 in the WAIT cycle after the request to 0x8:
  - flush_o pulses once.
  - The 0x8 data is discarded.
  - The next request address is 0x100 and the next v_o has pc_o = 0x100.
- branch_i in the same cycle as imem_ack_i, target 0x40:
  - The acked data never appears on v_o.
  - The next request is 0x40 and the drop flag stays clear.
- branch_i during HOLD with stall_i = 0:
  - The instruction is not counted as consumed.
  - v_o = 0 and flush_o = 1 on the next cycle.
  - Under FETCH_STATS_EN: stat_drop_o increments and stat_fetch_o is unchanged.
- Wrap: branch to 0xFFFFFFFC, then sequential fetch gives the next request at 0x0.
- Reset mid-WAIT: the late ack is ignored and the first request after reset is to RESET_PC.
